// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// Optional feature macro: FETCH_PC_OVF_TRAP_EN (PC overflow trap, see fetch_pc_reg / fetch_unit).
package fetch_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    // Latency counter is sized for the largest supported ROM latency.
    localparam int unsigned MAX_MEM_LAT = 4;
    localparam int unsigned LAT_W       = $clog2(MAX_MEM_LAT + 1);

    // IR contents after reset or flush unless overridden by NOP_WORD.
    localparam int unsigned DEFAULT_NOP = 0;

    // Counter preload for a fetch: counts down to zero on the capture edge.
    function automatic logic [LAT_W-1:0] lat_init(input int unsigned mem_lat);
        return LAT_W'(mem_lat - 1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Control/ROM/decoder side signals of the fetch unit.
// Optional feature macro: FETCH_PC_OVF_TRAP_EN adds the pc_ovf status signal.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned INSTR_W = 16
);
    logic               fetch_req;
    logic               pc_ld;
    logic [ADDR_W-1:0]  pc_ld_addr;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd;
    logic [INSTR_W-1:0] mem_q;
    logic [INSTR_W-1:0] ir;
    logic               ir_valid;
    logic               busy;
    logic [ADDR_W-1:0]  pc;
`ifdef FETCH_PC_OVF_TRAP_EN
    logic               pc_ovf;
`endif

    // Environment side: control FSM, ROM and decoder.
    modport master (
        output fetch_req,
        output pc_ld,
        output pc_ld_addr,
        output mem_q,
        input  mem_addr,
        input  mem_rd,
        input  ir,
        input  ir_valid,
        input  busy,
`ifdef FETCH_PC_OVF_TRAP_EN
        input  pc_ovf,
`endif
        input  pc
    );

    // Fetch unit side.
    modport slave (
        input  fetch_req,
        input  pc_ld,
        input  pc_ld_addr,
        input  mem_q,
        output mem_addr,
        output mem_rd,
        output ir,
        output ir_valid,
        output busy,
`ifdef FETCH_PC_OVF_TRAP_EN
        output pc_ovf,
`endif
        output pc
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register: async clear, load (jump) with priority over increment.
// Optional feature macro: FETCH_PC_OVF_TRAP_EN -- increment at all-ones holds the PC and
// sets a sticky overflow flag instead of wrapping; a load clears the flag.
module fetch_pc_reg #(
    parameter int unsigned      ADDR_W   = 7,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Clr,
    input  logic              ld,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              inc,
`ifdef FETCH_PC_OVF_TRAP_EN
    output logic              ovf,
`endif
    output logic [ADDR_W-1:0] pc
);

`ifdef FETCH_PC_OVF_TRAP_EN
    // PC update with overflow trap: hold at all-ones and flag it.
    always_ff @(posedge Clock or posedge Clr) begin
        if (Clr) begin
            pc  <= RESET_PC;
            ovf <= 1'b0;
        end else if (ld) begin
            pc  <= ld_addr;
            ovf <= 1'b0;
        end else if (inc) begin
            if (&pc) begin
                ovf <= 1'b1;
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end
`else
    // PC update: load wins over increment, increment wraps modulo 2^ADDR_W.
    always_ff @(posedge Clock or posedge Clr) begin
        if (Clr) begin
            pc <= RESET_PC;
        end else if (ld) begin
            pc <= ld_addr;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, fetch FSM with ROM latency counter, and instruction register.
// A fetch accepted in IDLE captures mem_q MEM_LAT edges later; pc_ld jumps or flushes.
// Optional feature macro: FETCH_PC_OVF_TRAP_EN (adds pc_ovf, blocks fetches after PC overflow).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 7,
    parameter int unsigned        INSTR_W  = 16,
    parameter int unsigned        MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(DEFAULT_NOP)
) (
    input logic         Clock,
    input logic         Clr,
    fetch_unit_if.slave bus
);

    fetch_state_e       state;
    logic [LAT_W-1:0]   lat_cnt;
    logic [INSTR_W-1:0] ir_reg;
    logic               ir_valid_reg;
    logic               busy_reg;
    logic [ADDR_W-1:0]  pc_cur;
    logic               ovf_block;
    logic               fetch_go;
    logic               pc_inc;

`ifdef FETCH_PC_OVF_TRAP_EN
    logic pc_ovf;
    assign ovf_block  = pc_ovf;
    assign bus.pc_ovf = pc_ovf;
`else
    assign ovf_block = 1'b0;
`endif

    // Fetch acceptance, ROM strobe/address and PC increment strobe.
    always_comb begin
        fetch_go     = (state == IDLE) && bus.fetch_req && !ovf_block;
        pc_inc       = (state == WAIT) && !bus.pc_ld && (lat_cnt == '0);
        bus.mem_rd   = fetch_go && !Clr;
        // A jump issued together with a fetch reads the jump target directly.
        bus.mem_addr = ((state == IDLE) && bus.pc_ld) ? bus.pc_ld_addr : pc_cur;
    end

    assign bus.ir       = ir_reg;
    assign bus.ir_valid = ir_valid_reg;
    assign bus.busy     = busy_reg;
    assign bus.pc       = pc_cur;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .Clock   (Clock),
        .Clr     (Clr),
        .ld      (bus.pc_ld),
        .ld_addr (bus.pc_ld_addr),
        .inc     (pc_inc),
`ifdef FETCH_PC_OVF_TRAP_EN
        .ovf     (pc_ovf),
`endif
        .pc      (pc_cur)
    );

    // Fetch FSM: latency countdown, IR capture or flush, registered status outputs.
    always_ff @(posedge Clock or posedge Clr) begin
        if (Clr) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            ir_reg       <= NOP_WORD;
            ir_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            ir_valid_reg <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fetch_go) begin
                        state    <= WAIT;
                        lat_cnt  <= lat_init(MEM_LAT);
                        busy_reg <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.pc_ld) begin
                        // Flush: in-flight ROM data is dropped.
                        state    <= IDLE;
                        lat_cnt  <= '0;
                        ir_reg   <= NOP_WORD;
                        busy_reg <= 1'b0;
                    end else if (lat_cnt == '0) begin
                        state        <= IDLE;
                        ir_reg       <= bus.mem_q;
                        ir_valid_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance with MEM_LAT=1 and one with MEM_LAT=3,
// each fed by a behavioural ROM with matching read latency.
// Honours FETCH_PC_OVF_TRAP_EN for the wrap/trap expectations.
module tb_fetch_unit;

    logic clk;
    logic clr;
    int   n_assert;
    int   n_fail;

    fetch_unit_if #(.ADDR_W(7), .INSTR_W(16)) if1 ();
    fetch_unit_if #(.ADDR_W(7), .INSTR_W(16)) if3 ();

    fetch_unit #(
        .ADDR_W   (7),
        .INSTR_W  (16),
        .MEM_LAT  (1),
        .RESET_PC (7'h00),
        .NOP_WORD (16'h0000)
    ) dut1 (
        .Clock (clk),
        .Clr   (clr),
        .bus   (if1)
    );

    fetch_unit #(
        .ADDR_W   (7),
        .INSTR_W  (16),
        .MEM_LAT  (3),
        .RESET_PC (7'h00),
        .NOP_WORD (16'h0000)
    ) dut3 (
        .Clock (clk),
        .Clr   (clr),
        .bus   (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM image: ROM[0]=1234, otherwise C000 | address.
    function automatic logic [15:0] rom_word(input logic [6:0] a);
        if (a == 7'h00) return 16'h1234;
        return {9'h180, a};
    endfunction

    logic [15:0] r3_s1;
    logic [15:0] r3_s2;

    // Synchronous ROMs: latency 1 for dut1, latency 3 for dut3.
    always @(posedge clk) begin
        if1.mem_q <= rom_word(if1.mem_addr);
        r3_s1     <= rom_word(if3.mem_addr);
        r3_s2     <= r3_s1;
        if3.mem_q <= r3_s2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        clr      = 1'b1;
        if1.fetch_req = 1'b0; if1.pc_ld = 1'b0; if1.pc_ld_addr = 7'h00;
        if3.fetch_req = 1'b0; if3.pc_ld = 1'b0; if3.pc_ld_addr = 7'h00;
        #3;

        // Reset state
        check("rst_pc",       32'(if1.pc), 32'h00);
        check("rst_ir",       32'(if1.ir), 32'h0000);
        check("rst_ir_valid", 32'(if1.ir_valid), 32'h0);
        check("rst_busy",     32'(if1.busy), 32'h0);
        check("rst_busy3",    32'(if3.busy), 32'h0);
        if1.fetch_req = 1'b1;
        if3.fetch_req = 1'b1;
        #1;
        check("rst_mem_rd_gated",  32'(if1.mem_rd), 32'h0);
        check("rst_mem_rd_gated3", 32'(if3.mem_rd), 32'h0);
        if1.fetch_req = 1'b0;
        if3.fetch_req = 1'b0;
        #5 clr = 1'b0;
        step();

        // Basic fetch, MEM_LAT=1
        if1.fetch_req = 1'b1;
        #1;
        check("b_mem_rd",   32'(if1.mem_rd), 32'h1);
        check("b_mem_addr", 32'(if1.mem_addr), 32'h00);
        step();
        if1.fetch_req = 1'b0;
        check("b_busy_wait",  32'(if1.busy), 32'h1);
        check("b_ivld_wait",  32'(if1.ir_valid), 32'h0);
        check("b_mem_rd_off", 32'(if1.mem_rd), 32'h0);
        step();
        check("b_ir",       32'(if1.ir), 32'h1234);
        check("b_ir_valid", 32'(if1.ir_valid), 32'h1);
        check("b_pc",       32'(if1.pc), 32'h01);
        check("b_busy_end", 32'(if1.busy), 32'h0);
        step();
        check("b_ivld_pulse", 32'(if1.ir_valid), 32'h0);
        check("b_ir_hold",    32'(if1.ir), 32'h1234);

        // Back-to-back fetches, one per two cycles
        if1.fetch_req = 1'b1;
        step();
        check("bb_busy1", 32'(if1.busy), 32'h1);
        step();
        check("bb_ir1",   32'(if1.ir), 32'hC001);
        check("bb_ivld1", 32'(if1.ir_valid), 32'h1);
        check("bb_pc1",   32'(if1.pc), 32'h02);
        step();
        if1.fetch_req = 1'b0;
        check("bb_busy2", 32'(if1.busy), 32'h1);
        check("bb_ivld2", 32'(if1.ir_valid), 32'h0);
        step();
        check("bb_ir2",   32'(if1.ir), 32'hC002);
        check("bb_pc2",   32'(if1.pc), 32'h03);

        // Jump bypass together with a fetch
        if1.pc_ld = 1'b1; if1.pc_ld_addr = 7'h40; if1.fetch_req = 1'b1;
        #1;
        check("j_mem_addr", 32'(if1.mem_addr), 32'h40);
        check("j_mem_rd",   32'(if1.mem_rd), 32'h1);
        step();
        if1.pc_ld = 1'b0; if1.fetch_req = 1'b0;
        check("j_pc_load", 32'(if1.pc), 32'h40);
        step();
        check("j_ir",   32'(if1.ir), 32'hC040);
        check("j_ivld", 32'(if1.ir_valid), 32'h1);
        check("j_pc",   32'(if1.pc), 32'h41);

        // Jump without fetch, then fetch at the top address
        if1.pc_ld = 1'b1; if1.pc_ld_addr = 7'h7F;
        step();
        if1.pc_ld = 1'b0;
        check("jl_pc",   32'(if1.pc), 32'h7F);
        check("jl_busy", 32'(if1.busy), 32'h0);
        if1.fetch_req = 1'b1;
        #1;
        check("w_mem_addr", 32'(if1.mem_addr), 32'h7F);
        step();
        if1.fetch_req = 1'b0;
        step();
        check("w_ir",   32'(if1.ir), 32'hC07F);
        check("w_ivld", 32'(if1.ir_valid), 32'h1);
`ifdef FETCH_PC_OVF_TRAP_EN
        check("t_pc_hold", 32'(if1.pc), 32'h7F);
        check("t_pc_ovf",  32'(if1.pc_ovf), 32'h1);
        if1.fetch_req = 1'b1;
        #1;
        check("t_mem_rd_blocked", 32'(if1.mem_rd), 32'h0);
        step();
        if1.fetch_req = 1'b0;
        check("t_busy_blocked", 32'(if1.busy), 32'h0);
        if1.pc_ld = 1'b1; if1.pc_ld_addr = 7'h05;
        step();
        if1.pc_ld = 1'b0;
        check("t_ovf_clear", 32'(if1.pc_ovf), 32'h0);
        check("t_pc_reload", 32'(if1.pc), 32'h05);
`else
        check("w_pc_wrap", 32'(if1.pc), 32'h00);
`endif

        // Latency 3, fetch_req held through WAIT
        if3.fetch_req = 1'b1;
        step();
        check("l_busy_e0", 32'(if3.busy), 32'h1);
        step();
        check("l_busy_e1", 32'(if3.busy), 32'h1);
        check("l_ivld_e1", 32'(if3.ir_valid), 32'h0);
        step();
        check("l_busy_e2", 32'(if3.busy), 32'h1);
        check("l_ivld_e2", 32'(if3.ir_valid), 32'h0);
        step();
        if3.fetch_req = 1'b0;
        check("l_ivld_e3", 32'(if3.ir_valid), 32'h1);
        check("l_ir_e3",   32'(if3.ir), 32'h1234);
        check("l_pc_e3",   32'(if3.pc), 32'h01);
        check("l_busy_e3", 32'(if3.busy), 32'h0);
        step();
        check("l_ivld_e4", 32'(if3.ir_valid), 32'h0);
        check("l_pc_once", 32'(if3.pc), 32'h01);

        // Asynchronous clear in the middle of WAIT
        if3.fetch_req = 1'b1;
        step();
        if3.fetch_req = 1'b0;
        step();
        #2 clr = 1'b1;
        #1;
        check("c_busy", 32'(if3.busy), 32'h0);
        check("c_pc",   32'(if3.pc), 32'h00);
        check("c_ir",   32'(if3.ir), 32'h0000);
        #1 clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("c_no_ivld", 32'(if3.ir_valid), 32'h0);
        end
        check("c_idle", 32'(if3.busy), 32'h0);

        // Refill IR, then flush one cycle into a fetch
        if3.fetch_req = 1'b1;
        step();
        if3.fetch_req = 1'b0;
        step(); step(); step();
        check("f_pre_ir", 32'(if3.ir), 32'h1234);
        check("f_pre_pc", 32'(if3.pc), 32'h01);
        if3.fetch_req = 1'b1;
        step();
        if3.fetch_req = 1'b0;
        step();
        if3.pc_ld = 1'b1; if3.pc_ld_addr = 7'h10;
        step();
        if3.pc_ld = 1'b0;
        check("f_pc",   32'(if3.pc), 32'h10);
        check("f_ir",   32'(if3.ir), 32'h0000);
        check("f_busy", 32'(if3.busy), 32'h0);
        check("f_ivld", 32'(if3.ir_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("f_no_ivld", 32'(if3.ir_valid), 32'h0);
        end
        check("f_ir_kept", 32'(if3.ir), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
